pipeline_hazard_controller: RTL
===============================

PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: ports clk and reset.
REQ-002 clk  input  1  clock; every register updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 id_valid  input  1  ID stage holds a real instruction (IF/ID output is not a bubble).
REQ-005 id_rn, id_rm  input  4 each  source register numbers of the instruction in ID.
REQ-006 id_rn_used, id_rm_used  input  1 each  the matching source field is actually read.
REQ-007 ex_load, ex_reg_write, ex_rd  input  1/1/4  ID/EX instruction is a load, writes a register, and its destination.
REQ-008 id_branch_taken  input  1  branch in ID has been resolved taken this cycle.
REQ-009 halt_req, step  input  1 each  debug halt level and single-step pulse.
REQ-010 cnt_clear  input  1  synchronous clear of both counters.
REQ-011 pc_enable, if_id_enable  output  1 each  enables for the PC and IF/ID registers.
REQ-012 cu_mux_nop  output  1  forces the control multiplexer outputs to zero (bubble into ID/EX).
REQ-013 if_id_flush  output  1  replaces the IF/ID contents with NOP on the next edge.
REQ-014 stall_count, flush_count  output  16 each  saturating event counters.
REQ-015 ctrl_state  output  2  current FSM state encoding.

Function
REQ-016 load_use SHALL be: ex_load & ex_reg_write & id_valid & ex_rd!=15 & ((id_rn_used & id_rn==ex_rd) | (id_rm_used & id_rm==ex_rd)).
REQ-017 The FSM SHALL have states RUN=00, HALT=01, STEP=10; encoding 11 is unreachable and SHALL recover to HALT.
REQ-018 In RUN or STEP: stall=load_use; pc_enable=if_id_enable=~stall; cu_mux_nop=stall; if_id_flush=id_branch_taken & ~stall. These outputs are combinational with zero cycles of latency.
REQ-019 Stall SHALL take priority over flush. A branch that coincides with a stall SHALL be re-evaluated in the next cycle.
REQ-020 In HALT: pc_enable=0, if_id_enable=0, cu_mux_nop=1, if_id_flush=0.
REQ-021 RUN->HALT when halt_req=1. The outputs of the transition cycle SHALL still follow RUN rules.
REQ-022 HALT->RUN when halt_req=0. HALT->STEP when halt_req=1 & step=1. Otherwise the FSM SHALL stay in HALT.
REQ-023 STEP SHALL return after a cycle with stall=0: to HALT if halt_req=1, else to RUN. If stall=1 in STEP, the FSM SHALL stay in STEP, so exactly one instruction advances per step.
REQ-024 step SHALL be ignored in RUN and STEP.
REQ-025 stall_count SHALL increment by 1 for every cycle with stall=1 in RUN or STEP. flush_count SHALL increment by 1 for every cycle with if_id_flush=1.
REQ-026 Both counters SHALL saturate at 16'hFFFF and never wrap.
REQ-027 cnt_clear=1 SHALL zero both counters on the next edge. Clear SHALL beat a simultaneous increment.
REQ-028 Back-to-back load_use cycles SHALL each stall and each count. There is no internal bubble limit.

Reset
REQ-029 While reset=0: state=RUN, both counters=0, and the outputs SHALL be forced to pc_enable=0, if_id_enable=0, cu_mux_nop=1, if_id_flush=0, ctrl_state=00.
REQ-030 Reset asserted mid-STEP or mid-HALT SHALL abandon that state immediately. After release the FSM SHALL be in RUN.
REQ-031 Normal RUN output rules SHALL apply from the first cycle after reset deasserts.

Structure
REQ-032 The shared package arm_pipe_pkg SHALL hold: the state typedef (RUN/HALT/STEP), the PC register number constant 15, and the counter width constant 16.
REQ-033 The saturating counter (increment, clear, saturate) SHALL be a sub-module sat_counter, instantiated twice.
REQ-034 Hazard compare, FSM and output decode SHALL live in pipeline_hazard_controller. It SHALL contain no other sub-modules.

Verification
REQ-035 Load-use: ex_load=1, ex_reg_write=1, ex_rd=3, id_rm=3, id_rm_used=1, id_valid=1 for one cycle -> pc_enable=0, if_id_enable=0, cu_mux_nop=1 that cycle; stall_count 0->1; next cycle (ex_load=0) pc_enable=1.
REQ-036 No false hazard: the same stimulus with ex_rd=15, or with id_rm_used=0, or with id_valid=0 -> no stall; stall_count stays 0.
REQ-037 Branch flush: id_branch_taken=1 with no hazard -> if_id_flush=1 for one cycle and flush_count=1. Branch together with load_use -> if_id_flush=0, stall=1.
REQ-038 Halt/step: halt_req=1 -> ctrl_state=01 next cycle with enables 0. A one-cycle step pulse -> exactly one cycle with pc_enable=1, then HALT. A step during a hazard holds STEP until stall clears.
REQ-039 Saturation and clear: force 65536 stall cycles -> stall_count=FFFF and held. cnt_clear together with stall -> 0.
REQ-040 Reset mid-STEP: drop reset while in STEP -> outputs forced per REQ-029 immediately; after release ctrl_state=00 and counters=0.

Source files
------------

// File: rtl/arm_pipe_pkg.sv
// +----------------------------------------------------------------------+
// | arm_pipe_pkg: shared types and constants for the pipeline control.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package arm_pipe_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'b00,
    HALT = 2'b01,
    STEP = 2'b10
  } ctrl_state_t;

  localparam logic [3:0] c_pc_reg    = 4'd15;
  localparam int         c_cnt_width = 16;

endpackage

`default_nettype wire

// File: rtl/pipeline_hazard_controller_if.sv
// +----------------------------------------------------------------------+
// | pipeline_hazard_controller_if: pipeline status in, control out.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface pipeline_hazard_controller_if;
  import arm_pipe_pkg::*;

  logic                   id_valid;
  logic [3:0]             id_rn;
  logic [3:0]             id_rm;
  logic                   id_rn_used;
  logic                   id_rm_used;
  logic                   ex_load;
  logic                   ex_reg_write;
  logic [3:0]             ex_rd;
  logic                   id_branch_taken;
  logic                   halt_req;
  logic                   step;
  logic                   cnt_clear;
  logic                   pc_enable;
  logic                   if_id_enable;
  logic                   cu_mux_nop;
  logic                   if_id_flush;
  logic [c_cnt_width-1:0] stall_count;
  logic [c_cnt_width-1:0] flush_count;
  logic [1:0]             ctrl_state;

  modport master (
    output id_valid, id_rn, id_rm, id_rn_used, id_rm_used,
           ex_load, ex_reg_write, ex_rd, id_branch_taken,
           halt_req, step, cnt_clear,
    input  pc_enable, if_id_enable, cu_mux_nop, if_id_flush,
           stall_count, flush_count, ctrl_state
  );

  modport slave (
    input  id_valid, id_rn, id_rm, id_rn_used, id_rm_used,
           ex_load, ex_reg_write, ex_rd, id_branch_taken,
           halt_req, step, cnt_clear,
    output pc_enable, if_id_enable, cu_mux_nop, if_id_flush,
           stall_count, flush_count, ctrl_state
  );

endinterface

`default_nettype wire

// File: rtl/pipeline_hazard_controller_sat_counter.sv
// +----------------------------------------------------------------------+
// | sat_counter: event counter with synchronous clear and saturation.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module sat_counter #(
  parameter int WIDTH = 16
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             clear,
  input  wire logic             inc,
  output logic      [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;

  // Clear wins over a same-cycle increment; the all-ones value is sticky.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (inc && (r_count != {WIDTH{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/pipeline_hazard_controller.sv
// +----------------------------------------------------------------------+
// | pipeline_hazard_controller: load-use stall, branch flush, debug FSM. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module pipeline_hazard_controller
  import arm_pipe_pkg::*;
(
  input wire logic                   clk,
  input wire logic                   reset,
  pipeline_hazard_controller_if.slave bus
);

  ctrl_state_t r_state;
  ctrl_state_t w_next;
  logic        w_load_use;
  logic        w_stall;
  logic        w_pc_en;
  logic        w_nop;
  logic        w_flush;

  // R15 is the PC and never forwarded through the register file, so it cannot hazard.
  assign w_load_use = bus.ex_load & bus.ex_reg_write & bus.id_valid &
                      (bus.ex_rd != c_pc_reg) &
                      ((bus.id_rn_used & (bus.id_rn == bus.ex_rd)) |
                       (bus.id_rm_used & (bus.id_rm == bus.ex_rd)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= RUN;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_stall = 1'b0;
    w_pc_en = 1'b0;
    w_nop   = 1'b1;
    w_flush = 1'b0;
    case (r_state)
      RUN: begin
        w_stall = w_load_use;
        w_pc_en = ~w_load_use;
        w_nop   = w_load_use;
        w_flush = bus.id_branch_taken & ~w_load_use;
        if (bus.halt_req) begin
          w_next = HALT;
        end
      end
      HALT: begin
        if (!bus.halt_req) begin
          w_next = RUN;
        end else if (bus.step) begin
          w_next = STEP;
        end
      end
      STEP: begin
        w_stall = w_load_use;
        w_pc_en = ~w_load_use;
        w_nop   = w_load_use;
        w_flush = bus.id_branch_taken & ~w_load_use;
        // Stay until the stepped instruction actually advances.
        if (!w_load_use) begin
          w_next = bus.halt_req ? HALT : RUN;
        end
      end
      default: begin
        w_next = HALT;
      end
    endcase
  end

  // Reset overrides the decode combinationally, not just at the next edge.
  assign bus.pc_enable    = reset & w_pc_en;
  assign bus.if_id_enable = reset & w_pc_en;
  assign bus.cu_mux_nop   = ~reset | w_nop;
  assign bus.if_id_flush  = reset & w_flush;
  assign bus.ctrl_state   = r_state;

  sat_counter #(.WIDTH(c_cnt_width)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (bus.cnt_clear),
    .inc   (reset & w_stall),
    .count (bus.stall_count)
  );

  sat_counter #(.WIDTH(c_cnt_width)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (bus.cnt_clear),
    .inc   (reset & w_flush),
    .count (bus.flush_count)
  );

endmodule

`default_nettype wire
